// File: rtl/picorv32_pcpi_arb.sv
// Round-robin arbiter that shares one multi-cycle PCPI coprocessor between two PCPI requesters.
// Losers are held off with pcpi_wait; the coprocessor response is routed back to the granted port.
module picorv32_pcpi_arb #(
    parameter logic [31:0] MATCH_MASK  = 32'hFE00007F,
    parameter logic [31:0] MATCH_VALUE = 32'h02000033,
    parameter int unsigned TIMEOUT     = 96
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        p0_pcpi_valid,
    input  logic [31:0] p0_pcpi_insn,
    input  logic [31:0] p0_pcpi_rs1,
    input  logic [31:0] p0_pcpi_rs2,
    output logic        p0_pcpi_wr,
    output logic [31:0] p0_pcpi_rd,
    output logic        p0_pcpi_wait,
    output logic        p0_pcpi_ready,

    input  logic        p1_pcpi_valid,
    input  logic [31:0] p1_pcpi_insn,
    input  logic [31:0] p1_pcpi_rs1,
    input  logic [31:0] p1_pcpi_rs2,
    output logic        p1_pcpi_wr,
    output logic [31:0] p1_pcpi_rd,
    output logic        p1_pcpi_wait,
    output logic        p1_pcpi_ready,

    output logic        co_pcpi_valid,
    output logic [31:0] co_pcpi_insn,
    output logic [31:0] co_pcpi_rs1,
    output logic [31:0] co_pcpi_rs2,
    input  logic        co_pcpi_wr,
    input  logic [31:0] co_pcpi_rd,
    input  logic        co_pcpi_wait,
    input  logic        co_pcpi_ready,

    output logic        timeout_err
);

    // TIMEOUT is expected in 2..255 so the grant timer fits in 8 bits.
    localparam int unsigned         TIMER_W    = 8;
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 gnt_q, gnt_d;
    logic                 last_q, last_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 timeout_err_q, timeout_err_d;
    logic [1:0]           wait_q, wait_d;

    logic req0, req1;
    logic in_grant, gnt_valid, timer_hit, abort_to;
    logic sel0, sel1, ready0, ready1, abort0, abort1;

    // Request pre-decode and grant-qualified status.
    always_comb begin
        req0      = p0_pcpi_valid && ((p0_pcpi_insn & MATCH_MASK) == MATCH_VALUE);
        req1      = p1_pcpi_valid && ((p1_pcpi_insn & MATCH_MASK) == MATCH_VALUE);
        in_grant  = (state_q == ST_GRANT);
        gnt_valid = gnt_q ? p1_pcpi_valid : p0_pcpi_valid;
        timer_hit = (timer_q == TIMER_LAST);
        abort_to  = in_grant && !co_pcpi_ready && gnt_valid && timer_hit;
        sel0      = in_grant && !gnt_q;
        sel1      = in_grant && gnt_q;
        ready0    = sel0 && co_pcpi_ready;
        ready1    = sel1 && co_pcpi_ready;
        abort0    = abort_to && !gnt_q;
        abort1    = abort_to && gnt_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            gnt_q         <= 1'b0;
            last_q        <= 1'b1;
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
            wait_q        <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            last_q        <= last_d;
            timer_q       <= timer_d;
            timeout_err_q <= timeout_err_d;
            wait_q        <= wait_d;
        end
    end

    // Next state: grants only from IDLE, DRAIN lets the unit flush before the next grant.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        last_d        = last_q;
        timer_d       = timer_q;
        timeout_err_d = timeout_err_q;
        // A port completing or being aborted this cycle must not see wait raised next cycle.
        wait_d[0]     = req0 && !ready0 && !abort0;
        wait_d[1]     = req1 && !ready1 && !abort1;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    gnt_d   = (req0 && req1) ? !last_q : req1;
                    last_d  = gnt_d;
                    timer_d = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (co_pcpi_ready) begin
                    state_d = ST_DRAIN;
                end else if (!gnt_valid) begin
                    state_d = ST_DRAIN;
                end else if (timer_hit) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_DRAIN;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_DRAIN: begin
                if (!co_pcpi_wait) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Forward mux to the coprocessor and zero-latency response routing.
    always_comb begin
        co_pcpi_valid = 1'b0;
        co_pcpi_insn  = '0;
        co_pcpi_rs1   = '0;
        co_pcpi_rs2   = '0;
        if (in_grant) begin
            co_pcpi_valid = 1'b1;
            co_pcpi_insn  = gnt_q ? p1_pcpi_insn : p0_pcpi_insn;
            co_pcpi_rs1   = gnt_q ? p1_pcpi_rs1  : p0_pcpi_rs1;
            co_pcpi_rs2   = gnt_q ? p1_pcpi_rs2  : p0_pcpi_rs2;
        end

        p0_pcpi_ready = ready0;
        p1_pcpi_ready = ready1;
        p0_pcpi_wr    = ready0 && co_pcpi_wr;
        p1_pcpi_wr    = ready1 && co_pcpi_wr;
        p0_pcpi_rd    = sel0 ? co_pcpi_rd : '0;
        p1_pcpi_rd    = sel1 ? co_pcpi_rd : '0;
        p0_pcpi_wait  = wait_q[0] && !ready0 && !abort0;
        p1_pcpi_wait  = wait_q[1] && !ready1 && !abort1;
        timeout_err   = timeout_err_q;
    end

endmodule

// File: tb/tb_picorv32_pcpi_arb.sv
// Bench for picorv32_pcpi_arb: two requester models, a stub multiplier coprocessor,
// and an arithmetic reference for RV32M multiply results and round-robin order.
`timescale 1ns/1ps
module tb_picorv32_pcpi_arb;

    localparam int unsigned TO      = 8;
    localparam logic [31:0] I_MUL   = 32'h02B50533;
    localparam logic [31:0] I_MULHU = 32'h02B53533;
    localparam logic [31:0] I_ADD   = 32'h00B50533;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        p_valid [2];
    logic [31:0] p_insn  [2];
    logic [31:0] p_rs1   [2];
    logic [31:0] p_rs2   [2];
    logic        p_wr    [2];
    logic [31:0] p_rd    [2];
    logic        p_wait  [2];
    logic        p_ready [2];
    logic        co_valid, co_wr, co_wait, co_ready, timeout_err;
    logic [31:0] co_insn, co_rs1, co_rs2, co_rd;

    always #5 clk = ~clk;

    picorv32_pcpi_arb #(.TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn),
        .p0_pcpi_valid(p_valid[0]), .p0_pcpi_insn(p_insn[0]), .p0_pcpi_rs1(p_rs1[0]), .p0_pcpi_rs2(p_rs2[0]),
        .p0_pcpi_wr(p_wr[0]), .p0_pcpi_rd(p_rd[0]), .p0_pcpi_wait(p_wait[0]), .p0_pcpi_ready(p_ready[0]),
        .p1_pcpi_valid(p_valid[1]), .p1_pcpi_insn(p_insn[1]), .p1_pcpi_rs1(p_rs1[1]), .p1_pcpi_rs2(p_rs2[1]),
        .p1_pcpi_wr(p_wr[1]), .p1_pcpi_rd(p_rd[1]), .p1_pcpi_wait(p_wait[1]), .p1_pcpi_ready(p_ready[1]),
        .co_pcpi_valid(co_valid), .co_pcpi_insn(co_insn), .co_pcpi_rs1(co_rs1), .co_pcpi_rs2(co_rs2),
        .co_pcpi_wr(co_wr), .co_pcpi_rd(co_rd), .co_pcpi_wait(co_wait), .co_pcpi_ready(co_ready),
        .timeout_err(timeout_err)
    );

    // RV32M multiply reference: f = funct3[1:0] (MUL, MULH, MULHSU, MULHU).
    function automatic logic [31:0] mref(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            2'd1:    p = sa * sb;
            2'd2:    p = sa * ub;
            default: p = ua * ub;
        endcase
        return (f == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Stub multiplier: random latency, holds wait one cycle past ready, aborts if valid drops.
    logic        cp_busy, cp_flush, cp_hang;
    int unsigned cp_cnt;
    logic [1:0]  cp_f;
    logic [31:0] cp_a, cp_b;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cp_busy <= 1'b0; cp_flush <= 1'b0; cp_cnt <= 0; cp_f <= '0; cp_a <= '0; cp_b <= '0;
            co_wait <= 1'b0; co_ready <= 1'b0; co_wr <= 1'b0; co_rd <= '0;
        end else begin
            co_ready <= 1'b0; co_wr <= 1'b0; co_rd <= '0;
            if (cp_busy) begin
                if (!co_valid) begin
                    cp_busy <= 1'b0; co_wait <= 1'b0;
                end else if (cp_cnt == 0 && !cp_hang) begin
                    co_ready <= 1'b1; co_wr <= 1'b1; co_rd <= mref(cp_f, cp_a, cp_b);
                    cp_busy <= 1'b0; cp_flush <= 1'b1;
                end else if (cp_cnt != 0) begin
                    cp_cnt <= cp_cnt - 1;
                end
            end else if (cp_flush) begin
                cp_flush <= 1'b0; co_wait <= 1'b0;
            end else if (co_valid && co_insn[6:0] == 7'h33 && co_insn[31:25] == 7'h01 && !co_insn[14]) begin
                cp_busy <= 1'b1; co_wait <= 1'b1; cp_cnt <= $urandom_range(4, 0);
                cp_f <= co_insn[13:12]; cp_a <= co_rs1; cp_b <= co_rs2;
            end
        end
    end

    // Monitor: completion order per port and co_pcpi_valid low gaps between grants.
    int unsigned ord_n = 0, gap_n = 0, low_run = 0, co_hi_cnt = 0;
    int unsigned ord_log [64];
    int unsigned gap_log [64];
    logic        seen_hi = 1'b0;
    always @(negedge clk) begin
        if (p_ready[0] || p_ready[1]) begin
            ord_log[ord_n % 64] <= p_ready[1] ? 1 : 0;
            ord_n <= ord_n + 1;
        end
        if (co_valid) begin
            co_hi_cnt <= co_hi_cnt + 1;
            seen_hi   <= 1'b1;
            low_run   <= 0;
            if (seen_hi && low_run != 0) begin
                gap_log[gap_n % 64] <= low_run;
                gap_n <= gap_n + 1;
            end
        end else begin
            low_run <= low_run + 1;
        end
    end

    logic [31:0] ctl_bits, data_or;
    assign ctl_bits = {24'b0, timeout_err, co_valid, p_wr[1], p_wr[0], p_wait[1], p_wait[0], p_ready[1], p_ready[0]};
    assign data_or  = co_insn | co_rs1 | co_rs2 | p_rd[0] | p_rd[1];

    int unsigned n_chk = 0, n_pass = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One requester transaction; counts cycles where wait differs from exp_wait while pending.
    task automatic run_req(input int n, input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                           input int unsigned limit, input logic exp_wait,
                           output logic acked, output logic wr, output logic [31:0] rd, output int unsigned wait_bad);
        int unsigned cyc;
        cyc = 0; acked = 1'b0; wr = 1'b0; rd = '0; wait_bad = 0;
        @(posedge clk); #1;
        p_valid[n] = 1'b1; p_insn[n] = insn; p_rs1[n] = a; p_rs2[n] = b;
        while (!acked && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (p_ready[n]) begin
                acked = 1'b1; wr = p_wr[n]; rd = p_rd[n];
            end else if (cyc > 1 && p_wait[n] !== exp_wait) begin
                wait_bad++;
            end
        end
        @(posedge clk); #1;
        p_valid[n] = 1'b0; p_insn[n] = '0; p_rs1[n] = '0; p_rs2[n] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk); resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic        ack0, ack1, wr0, wr1, got, done;
    logic [31:0] rd0, rd1;
    int unsigned wb0, wb1, cyc, noise, n, o0, g0, hi0, mn;
    int unsigned sbad0, sbad1;

    initial begin
        for (int i = 0; i < 2; i++) begin
            p_valid[i] = 1'b0; p_insn[i] = '0; p_rs1[i] = '0; p_rs2[i] = '0;
        end
        cp_hang = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", ctl_bits, 32'h0);
        chk("reset_data", data_or, 32'h0);
        resetn = 1'b1;

        // Single MUL on port 0.
        @(posedge clk); #1;
        p_valid[0] = 1'b1; p_insn[0] = I_MUL; p_rs1[0] = 32'd7; p_rs2[0] = 32'd6;
        @(negedge clk); chk("t1_co_not_yet", 32'(co_valid), 32'd0);
        @(negedge clk); chk("t1_co_valid", 32'(co_valid), 32'd1);
        chk("t1_co_rs1", co_rs1, 32'd7);
        got = 1'b0; cyc = 0; noise = 0;
        while (!got && cyc < 50) begin
            if (p_wr[1] || p_ready[1] || p_wait[1] || p_rd[1] != 0) noise++;
            if (p_ready[0]) begin
                got = 1'b1;
                chk("t1_wr", 32'(p_wr[0]), 32'd1);
                chk("t1_rd", p_rd[0], 32'd42);
            end else begin
                @(negedge clk); cyc++;
            end
        end
        chk("t1_acked", 32'(got), 32'd1);
        chk("t1_p1_quiet", noise, 32'd0);
        @(posedge clk); #1; p_valid[0] = 1'b0; p_insn[0] = '0; p_rs1[0] = '0; p_rs2[0] = '0;
        @(negedge clk); chk("t1_ready_once", 32'(p_ready[0]), 32'd0);

        // Simultaneous MULHU from both ports after reset: port 0 first.
        do_reset();
        o0 = ord_n; g0 = gap_n;
        fork
            run_req(0, I_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 200, 1'b1, ack0, wr0, rd0, wb0);
            run_req(1, I_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 200, 1'b1, ack1, wr1, rd1, wb1);
        join
        chk("t2_acks", {30'b0, ack1, ack0}, 32'd3);
        chk("t2_rd0", rd0, 32'hFFFFFFFE);
        chk("t2_rd1", rd1, 32'hFFFFFFFE);
        chk("t2_p0_wait", wb0, 32'd0);
        chk("t2_p1_wait_held", wb1, 32'd0);
        chk("t2_first", ord_log[o0 % 64], 32'd0);
        chk("t2_second", ord_log[(o0 + 1) % 64], 32'd1);
        mn = 1000;
        for (int unsigned k = g0; k < gap_n; k++) if (gap_log[k % 64] < mn) mn = gap_log[k % 64];
        chk("t2_gap_ge2", 32'(mn >= 2), 32'd1);

        // Non-M instruction is never acknowledged or forwarded.
        hi0 = co_hi_cnt;
        run_req(1, I_ADD, 32'd5, 32'd6, 20, 1'b0, ack1, wr1, rd1, wb1);
        chk("t3_no_ack", 32'(ack1), 32'd0);
        chk("t3_no_wait", wb1, 32'd0);
        chk("t3_no_co", co_hi_cnt - hi0, 32'd0);

        // Coprocessor never completes: forced abort after TO grant cycles.
        cp_hang = 1'b1;
        @(posedge clk); #1;
        p_valid[0] = 1'b1; p_insn[0] = I_MUL; p_rs1[0] = 32'd3; p_rs2[0] = 32'd4;
        n = 0; done = 1'b0; cyc = 0;
        while (!done && cyc < 60) begin
            @(negedge clk); cyc++;
            if (co_valid) begin
                n++;
                if (n == TO - 1) chk("t4_wait_pre", 32'(p_wait[0]), 32'd1);
                if (n == TO) begin
                    chk("t4_abort_wait", 32'(p_wait[0]), 32'd0);
                    chk("t4_abort_rdy_wr", {30'b0, p_ready[0], p_wr[0]}, 32'd0);
                end
            end else if (n > 0) begin
                done = 1'b1;
            end
        end
        chk("t4_grant_cycles", n, TO);
        chk("t4_err", 32'(timeout_err), 32'd1);
        chk("t4_wait_after", 32'(p_wait[0]), 32'd0);
        @(posedge clk); #1; p_valid[0] = 1'b0; p_insn[0] = '0; p_rs1[0] = '0; p_rs2[0] = '0;
        cp_hang = 1'b0;
        repeat (4) @(negedge clk);
        chk("t4_idle", 32'(co_valid), 32'd0);
        chk("t4_err_sticky", 32'(timeout_err), 32'd1);

        // Both ports stream random multiplies: grants alternate, results match reference.
        do_reset();
        chk("t5_err_cleared", 32'(timeout_err), 32'd0);
        o0 = ord_n; g0 = gap_n; sbad0 = 0; sbad1 = 0;
        fork
            begin : s0
                logic [1:0] f; logic [31:0] a, b, r; logic ak, w; int unsigned wb;
                for (int k = 0; k < 5; k++) begin
                    f = 2'($urandom_range(3, 0)); a = $urandom; b = $urandom;
                    run_req(0, {7'h01, 5'd11, 5'd10, 1'b0, f, 5'd10, 7'h33}, a, b, 200, 1'b1, ak, w, r, wb);
                    chk("t5_p0_rd", r, mref(f, a, b));
                    if (!ak || !w) sbad0++;
                    sbad0 += wb;
                end
            end
            begin : s1
                logic [1:0] f; logic [31:0] a, b, r; logic ak, w; int unsigned wb;
                for (int k = 0; k < 5; k++) begin
                    f = 2'($urandom_range(3, 0)); a = $urandom; b = $urandom;
                    run_req(1, {7'h01, 5'd11, 5'd10, 1'b0, f, 5'd10, 7'h33}, a, b, 200, 1'b1, ak, w, r, wb);
                    chk("t5_p1_rd", r, mref(f, a, b));
                    if (!ak || !w) sbad1++;
                    sbad1 += wb;
                end
            end
        join
        chk("t5_p0_handshake", sbad0, 32'd0);
        chk("t5_p1_handshake", sbad1, 32'd0);
        chk("t5_count", ord_n - o0, 32'd10);
        for (int unsigned k = 0; k < 10; k++) chk("t5_order", ord_log[(o0 + k) % 64], k % 2);
        mn = 1000;
        for (int unsigned k = g0; k < gap_n; k++) if (gap_log[k % 64] < mn) mn = gap_log[k % 64];
        chk("t5_gap_ge2", 32'(mn >= 2), 32'd1);

        // Reset mid-grant clears all outputs at once; port 0 wins afterwards.
        @(posedge clk); #1;
        p_valid[0] = 1'b1; p_insn[0] = I_MUL; p_rs1[0] = 32'd2; p_rs2[0] = 32'd2;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!co_valid && cyc < 20);
        chk("t6_granted", 32'(co_valid), 32'd1);
        #1 resetn = 1'b0;
        #1 chk("t6_rst_ctl", ctl_bits, 32'h0);
        chk("t6_rst_data", data_or, 32'h0);
        p_valid[0] = 1'b0; p_insn[0] = '0; p_rs1[0] = '0; p_rs2[0] = '0;
        @(negedge clk); resetn = 1'b1;
        o0 = ord_n;
        fork
            run_req(0, I_MUL, 32'd9, 32'd9, 200, 1'b1, ack0, wr0, rd0, wb0);
            run_req(1, I_MUL, 32'd3, 32'd5, 200, 1'b1, ack1, wr1, rd1, wb1);
        join
        chk("t6_first_p0", ord_log[o0 % 64], 32'd0);
        chk("t6_rd0", rd0, 32'd81);
        chk("t6_rd1", rd1, 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/picorv32_pcpi_arb.md
Name: picorv32_pcpi_arb

Overview:
- Shares one multi-cycle PCPI coprocessor (the MUL unit) between two PCPI requester ports, e.g. two cores or a core plus a test master.
- Pre-decodes requests and grants the coprocessor round-robin.
- Holds off losing requesters with pcpi_wait so their 16-cycle core timeout cannot fire, and routes the result back to the granted port.
- Sits between the core PCPI buses and the coprocessor PCPI slave port.

Parameters:
- MATCH_MASK, 32'hFE00007F: insn bits compared for decode.
- MATCH_VALUE, 32'h02000033: required value of masked bits (RV32M OP, funct7=0000001).
- TIMEOUT, 96: max cycles in GRANT without co_pcpi_ready before forced abort; must be 2..255.

Ports:
- clk  in  1  clock, all flops rising edge.
- resetn  in  1  asynchronous active-low reset.
- pN_pcpi_valid  in  1  requester N valid, N=0,1.
- pN_pcpi_insn  in  32  requester N instruction.
- pN_pcpi_rs1  in  32  requester N operand 1.
- pN_pcpi_rs2  in  32  requester N operand 2.
- pN_pcpi_wr  out  1  requester N write-back strobe.
- pN_pcpi_rd  out  32  requester N result.
- pN_pcpi_wait  out  1  requester N hold-off.
- pN_pcpi_ready  out  1  requester N completion.
- co_pcpi_valid  out  1  to coprocessor.
- co_pcpi_insn  out  32  to coprocessor.
- co_pcpi_rs1  out  32  to coprocessor.
- co_pcpi_rs2  out  32  to coprocessor.
- co_pcpi_wr  in  1  from coprocessor.
- co_pcpi_rd  in  32  from coprocessor.
- co_pcpi_wait  in  1  from coprocessor.
- co_pcpi_ready  in  1  from coprocessor.
- timeout_err  out  1  sticky: a forced abort occurred.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, gnt=0, last=1 (port 0 wins first), timer=0, timeout_err=0.
  - All outputs 0.
- Decode: reqN = pN_pcpi_valid && ((pN_pcpi_insn & MATCH_MASK) == MATCH_VALUE). Non-matching valid requests are never acknowledged, so the core's own timeout traps them.
- pN_pcpi_wait is a registered copy of reqN.
  - Goes high one cycle after reqN, whether or not port N is granted.
  - Forced 0 in the cycle pN_pcpi_ready is high and during the abort cycle.
- State machine (state, gnt, last, timer are registers):
  - IDLE:
    - No req: stay.
    - Exactly one req: gnt=that port.
    - Both req: gnt=!last.
    - On any grant: last=gnt, timer=0, go GRANT.
  - GRANT:
    - co_pcpi_valid=1; co_pcpi_insn/rs1/rs2 = gnt port inputs (combinational mux).
    - co_pcpi_ready=1: go DRAIN.
    - Else if granted pN_pcpi_valid drops (requester abort): go DRAIN.
    - Else if timer==TIMEOUT-1: set timeout_err=1, go DRAIN.
    - Otherwise timer increments each cycle.
  - DRAIN:
    - co_pcpi_valid=0, co_pcpi_insn/rs1/rs2 = 0.
    - Stay until co_pcpi_wait==0 (minimum 1 cycle); this lets the unit's registered decode/wait pipeline flush.
    - Then go IDLE.
- Arbitration takes effect only from IDLE; DRAIN never grants directly, so back-to-back transactions have at least DRAIN + IDLE (2 cycles) of co_pcpi_valid low.
- Response path is combinational, zero added latency. In GRANT:
  - pN_pcpi_ready = co_pcpi_ready && gnt==N.
  - pN_pcpi_wr = co_pcpi_wr && co_pcpi_ready && gnt==N.
  - pN_pcpi_rd = co_pcpi_rd when gnt==N, else 0.
  - Non-granted port: ready=wr=0, rd=0.
- Timeout abort: for one cycle (the GRANT cycle with timer==TIMEOUT-1), the granted port sees wait=0, ready=0, wr=0, so the core's timeout traps. The abort cycle's registered wait must also not raise wait in the following cycle. The port may re-request afterwards. timeout_err clears only on reset.
- Ready together with abort or timeout in the same cycle: ready takes precedence; result delivered; timeout_err not set.
- The loser of a simultaneous request stays pending with wait=1 and is served next by round-robin. A steady stream from one port cannot starve the other.
- Request arriving while in DRAIN: sampled in IDLE next cycle.
- Reset mid-GRANT: all outputs 0 asynchronously; coprocessor sees co_pcpi_valid drop immediately.

Test Plan:
- p0 MUL (insn 0x02B50533), rs1=7, rs2=6, p1 idle → co_pcpi_valid high 1 cycle after p0 valid; p0_pcpi_wr=p0_pcpi_ready=1 for one cycle with p0_pcpi_rd=42; p1 outputs stay 0.
- p0 and p1 MULHU (0x02B53533) same cycle, rs1=rs2=0xFFFFFFFF → p0 served first, rd=0xFFFFFFFE. p1_pcpi_wait=1 throughout. p1 served second, rd=0xFFFFFFFE, with ≥2 cycles of co_pcpi_valid low between grants.
- p1 issues ADD (0x00B50533) → p1_pcpi_wait, co_pcpi_valid, p1_pcpi_ready all remain 0 for 20 cycles.
- TIMEOUT=8, stub coprocessor asserts wait but never ready → after 8 GRANT cycles: timeout_err=1, p0_pcpi_wait=0, co_pcpi_valid=0; arbiter returns to IDLE.
- Both ports stream MULs back-to-back for 10 transactions → grants alternate p0,p1,p0,…; every result matches the golden product.
- resetn pulsed low mid-GRANT → all outputs 0 within the reset cycle. After release, port 0 wins the next simultaneous request.
